// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, ACK levels and the target FSM state type
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP} i2cTargetState_t;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: two-flop synchroniser plus run-length debounce for one bus line
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  logic [1:0] sync;
  logic [3:0] cnt;
  // output follows the synchronised line only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) cnt <= '0;
      else if (cnt == 4'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        filt <= sync[1];
      end else cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/i2c_target_unit.sv
// i2c_target_unit: I2C target byte engine with START/STOP detection, address match and ACK handling
module i2c_target_unit import i2c_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
  parameter int                    FILTER_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclIn,
  input  logic                  sdaIn,
  output logic                  sdaOe,
  input  logic [I2C_BYTE_W-1:0] txData,
  output logic                  txLoad,
  output logic [I2C_BYTE_W-1:0] rxData,
  output logic                  rxValid,
  output logic                  readMode,
  output logic                  busy,
  output logic                  stopSeen
);
  i2cTargetState_t state, state_nx;
  logic scl, sda, scl_q, sda_q;
  logic [I2C_BYTE_W-1:0] shifter, shifter_nx, rx_data_nx, shift_in;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic acked, acked_nx, sda_oe_nx, tx_load_nx, rx_valid_nx, read_mode_nx, busy_nx, stop_seen_nx;
  logic scl_rise, scl_fall, start, stop, last_bit, addr_hit;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (.clk(clk), .reset(reset), .raw(sclIn), .filt(scl));
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (.clk(clk), .reset(reset), .raw(sdaIn), .filt(sda));

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;
  assign shift_in = {shifter[I2C_BYTE_W-2:0], sda};
  assign last_bit = bit_cnt == 3'd7;
  assign addr_hit = shifter[I2C_ADDR_W-1:0] == TARGET_ADDR && shifter[I2C_ADDR_W-1:0] != '0;

  // state register together with the datapath and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      shifter  <= '0;
      bit_cnt  <= '0;
      acked    <= 1'b0;
      sdaOe    <= 1'b0;
      txLoad   <= 1'b0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      readMode <= 1'b0;
      busy     <= 1'b0;
      stopSeen <= 1'b0;
    end else begin
      state    <= state_nx;
      scl_q    <= scl;
      sda_q    <= sda;
      shifter  <= shifter_nx;
      bit_cnt  <= bit_cnt_nx;
      acked    <= acked_nx;
      sdaOe    <= sda_oe_nx;
      txLoad   <= tx_load_nx;
      rxData   <= rx_data_nx;
      rxValid  <= rx_valid_nx;
      readMode <= read_mode_nx;
      busy     <= busy_nx;
      stopSeen <= stop_seen_nx;
    end

  // next state: START/STOP win over every bit-level event
  always_comb begin
    state_nx = state;
    if (start) state_nx = ADDR;
    else if (stop) state_nx = IDLE;
    else
      case (state)
        ADDR:     if (scl_rise && last_bit) state_nx = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && sdaOe) state_nx = readMode ? TX : RX;
        RX:       if (scl_rise && last_bit) state_nx = RX_ACK;
        RX_ACK:   if (scl_fall && sdaOe) state_nx = RX;
        TX:       if (scl_fall && last_bit) state_nx = TX_ACK;
        TX_ACK:   state_nx = (scl_rise && sda == NACK) ? WAIT_STOP : (scl_fall && acked) ? TX : state;
        default:  ;
      endcase
  end

  // datapath and output updates; sdaOe only moves on a filtered SCL fall or START/STOP
  always_comb begin
    shifter_nx   = shifter;
    bit_cnt_nx   = bit_cnt;
    acked_nx     = acked;
    sda_oe_nx    = sdaOe;
    tx_load_nx   = 1'b0;
    rx_data_nx   = rxData;
    rx_valid_nx  = 1'b0;
    read_mode_nx = readMode;
    busy_nx      = busy;
    stop_seen_nx = 1'b0;
    if (start) begin
      bit_cnt_nx = '0;
      sda_oe_nx  = 1'b0;
      acked_nx   = 1'b0;
    end else if (stop) begin
      sda_oe_nx    = 1'b0;
      busy_nx      = 1'b0;
      stop_seen_nx = 1'b1;
    end else
      case (state)
        ADDR: if (scl_rise) begin
          shifter_nx = shift_in;
          bit_cnt_nx = bit_cnt + 3'd1;
          if (last_bit) begin
            read_mode_nx = addr_hit ? sda : readMode;
            busy_nx      = addr_hit;
          end
        end
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!sdaOe) sda_oe_nx = 1'b1;
          else if (state == ADDR_ACK && readMode) begin
            tx_load_nx = 1'b1;
            shifter_nx = txData;
            sda_oe_nx  = ~txData[I2C_BYTE_W-1];
          end else sda_oe_nx = 1'b0;
        end
        RX: if (scl_rise) begin
          shifter_nx = shift_in;
          bit_cnt_nx = bit_cnt + 3'd1;
          if (last_bit) begin
            rx_data_nx  = shift_in;
            rx_valid_nx = 1'b1;
          end
        end
        TX: if (scl_fall) begin
          shifter_nx = {shifter[I2C_BYTE_W-2:0], 1'b0};
          bit_cnt_nx = bit_cnt + 3'd1;
          sda_oe_nx  = last_bit ? 1'b0 : ~shifter[I2C_BYTE_W-2];
        end
        TX_ACK:
          if (scl_rise) acked_nx = sda == ACK;
          else if (scl_fall && acked) begin
            acked_nx   = 1'b0;
            tx_load_nx = 1'b1;
            shifter_nx = txData;
            sda_oe_nx  = ~txData[I2C_BYTE_W-1];
          end
        WAIT_STOP: sda_oe_nx = 1'b0;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_i2c_target_unit.sv
// tb_i2c_target_unit: directed and randomized I2C controller transfers checked against a bus-level model
module tb_i2c_target_unit;
  import i2c_pkg::*;
  localparam int Q = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  logic sda_bus, sdaOe, txLoad, rxValid, readMode, busy, stopSeen;
  logic [7:0] txData, rxData;
  logic [7:0] tx_arr [64];
  logic [7:0] rx_log [64];
  int tx_idx = 0, rx_cnt = 0, stop_cnt = 0, oe_cnt = 0, oe_bad = 0;
  int total = 0, passed = 0, fails = 0;
  logic prev_oe = 1'b0;

  assign sda_bus = sda_drv & ~sdaOe;
  assign txData  = tx_arr[tx_idx[5:0]];

  i2c_target_unit dut (
    .clk(clk), .reset(reset), .sclIn(scl_drv), .sdaIn(sda_bus), .sdaOe(sdaOe),
    .txData(txData), .txLoad(txLoad), .rxData(rxData), .rxValid(rxValid),
    .readMode(readMode), .busy(busy), .stopSeen(stopSeen)
  );

  always #5 clk = ~clk;

  // bus observer: host-side byte logs, pulse counters and SDA-while-SCL-high watch
  always @(negedge clk) begin
    if (txLoad) tx_idx <= tx_idx + 1;
    if (rxValid) begin
      rx_log[rx_cnt[5:0]] <= rxData;
      rx_cnt <= rx_cnt + 1;
    end
    if (stopSeen) stop_cnt <= stop_cnt + 1;
    if (sdaOe) oe_cnt <= oe_cnt + 1;
    if (sdaOe !== prev_oe && scl_drv) oe_bad <= oe_bad + 1;
    prev_oe <= sdaOe;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed += 1;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cond();
    sda_drv = 1'b1; cyc(Q);
    scl_drv = 1'b1; cyc(Q);
    sda_drv = 1'b0; cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0; cyc(Q);
    scl_drv = 1'b1; cyc(Q);
    sda_drv = 1'b1; cyc(Q);
  endtask

  task automatic bit_cycle(input logic b, output logic r);
    sda_drv = b; cyc(Q);
    scl_drv = 1'b1; cyc(Q);
    r = sda_bus; cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
    bit_cycle(1'b1, ack);
  endtask

  task automatic rd_byte(input logic a, output logic [7:0] d);
    logic r;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, r);
      d = {d[6:0], r};
    end
    bit_cycle(a, r);
  endtask

  task automatic glitch(input int n);
    cyc(6);
    scl_drv = 1'b1; cyc(n);
    scl_drv = 1'b0; cyc(Q);
  endtask

  initial begin
    logic ack, r;
    logic [7:0] d;
    logic [7:0] wv [3];
    logic [6:0] a;
    logic rw, m;
    int rb, sb, tb0, oe0, n;
    cyc(4);
    chk("rst_sdaOe", 32'(sdaOe), 0);
    chk("rst_txLoad", 32'(txLoad), 0);
    chk("rst_rxData", 32'(rxData), 0);
    chk("rst_rxValid", 32'(rxValid), 0);
    chk("rst_readMode", 32'(readMode), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stopSeen", 32'(stopSeen), 0);
    reset = 1'b1;
    cyc(4);

    rb = rx_cnt; sb = stop_cnt;
    start_cond();
    wr_byte(8'h84, ack); chk("t1_addr_ack", 32'(ack), 32'(ACK));
    chk("t1_busy", 32'(busy), 1);
    chk("t1_readMode", 32'(readMode), 0);
    wr_byte(8'hA5, ack); chk("t1_d0_ack", 32'(ack), 32'(ACK));
    wr_byte(8'h3C, ack); chk("t1_d1_ack", 32'(ack), 32'(ACK));
    stop_cond(); cyc(12);
    chk("t1_rx_cnt", 32'(rx_cnt - rb), 2);
    chk("t1_rx0", 32'(rx_log[6'(rb)]), 32'h A5);
    chk("t1_rx1", 32'(rx_log[6'(rb + 1)]), 32'h3C);
    chk("t1_stops", 32'(stop_cnt - sb), 1);
    chk("t1_busy_end", 32'(busy), 0);

    tb0 = tx_idx;
    tx_arr[6'(tb0)] = 8'h96;
    tx_arr[6'(tb0 + 1)] = 8'h0F;
    start_cond();
    wr_byte(8'h85, ack); chk("t2_addr_ack", 32'(ack), 32'(ACK));
    chk("t2_readMode", 32'(readMode), 1);
    rd_byte(ACK, d); chk("t2_rd0", 32'(d), 32'h96);
    rd_byte(NACK, d); chk("t2_rd1", 32'(d), 32'h0F);
    cyc(Q);
    chk("t2_txloads", 32'(tx_idx - tb0), 2);
    chk("t2_wait_stop", 32'(dut.state), 32'(WAIT_STOP));
    chk("t2_busy_nack", 32'(busy), 1);
    chk("t2_sdaOe_nack", 32'(sdaOe), 0);
    stop_cond(); cyc(12);
    chk("t2_busy_end", 32'(busy), 0);

    oe0 = oe_cnt; rb = rx_cnt;
    start_cond();
    wr_byte(8'h44, ack); chk("t3_addr_nack", 32'(ack), 32'(NACK));
    chk("t3_busy", 32'(busy), 0);
    wr_byte(8'h55, ack); chk("t3_d_nack", 32'(ack), 32'(NACK));
    stop_cond(); cyc(12);
    chk("t3_no_oe", 32'(oe_cnt - oe0), 0);
    chk("t3_no_rx", 32'(rx_cnt - rb), 0);

    rb = rx_cnt;
    tx_arr[6'(tx_idx)] = 8'hC3;
    start_cond();
    wr_byte(8'h84, ack); chk("t4_addr_ack", 32'(ack), 32'(ACK));
    chk("t4_readMode_w", 32'(readMode), 0);
    wr_byte(8'h11, ack); chk("t4_d_ack", 32'(ack), 32'(ACK));
    start_cond();
    wr_byte(8'h85, ack); chk("t4_raddr_ack", 32'(ack), 32'(ACK));
    chk("t4_readMode_r", 32'(readMode), 1);
    rd_byte(NACK, d); chk("t4_rd", 32'(d), 32'hC3);
    stop_cond(); cyc(12);
    chk("t4_rx_cnt", 32'(rx_cnt - rb), 1);
    chk("t4_rx0", 32'(rx_log[6'(rb)]), 32'h11);
    chk("t4_busy_end", 32'(busy), 0);

    rb = rx_cnt;
    start_cond();
    wr_byte(8'h84, ack); chk("t5_addr_ack", 32'(ack), 32'(ACK));
    glitch(2);
    wr_byte(8'h3A, ack); chk("t5_short_ack", 32'(ack), 32'(ACK));
    glitch(5);
    wr_byte(8'h3A, ack); chk("t5_long_ack", 32'(ack), 32'(NACK));
    stop_cond(); cyc(12);
    chk("t5_rx_cnt", 32'(rx_cnt - rb), 2);
    chk("t5_short_rx", 32'(rx_log[6'(rb)]), 32'h3A);
    chk("t5_long_rx", 32'(rx_log[6'(rb + 1)]), 32'h9D);

    start_cond();
    for (int i = 7; i >= 0; i--) bit_cycle(d[0] | 1'b1 ? 1'(8'h84 >> i) : 1'b0, r);
    sda_drv = 1'b1; cyc(Q);
    chk("t6_ack_drive", 32'(sdaOe), 1);
    reset = 1'b0; #1;
    chk("t6_async_release", 32'(sdaOe), 0);
    cyc(3); reset = 1'b1; cyc(4);
    rb = rx_cnt;
    start_cond();
    wr_byte(8'h84, ack); chk("t6_addr_ack", 32'(ack), 32'(ACK));
    wr_byte(8'h5A, ack); chk("t6_d_ack", 32'(ack), 32'(ACK));
    stop_cond(); cyc(12);
    chk("t6_rx_cnt", 32'(rx_cnt - rb), 1);
    chk("t6_rx0", 32'(rx_log[6'(rb)]), 32'h5A);
    chk("t6_busy_end", 32'(busy), 0);

    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(2))
        0: a = 7'h42;
        1: a = 7'h00;
        default: a = 7'($urandom);
      endcase
      rw = 1'($urandom);
      n = $urandom_range(3, 1);
      m = a == 7'h42;
      rb = rx_cnt; sb = stop_cnt; tb0 = tx_idx;
      for (int i = 0; i < 3; i++) begin
        tx_arr[6'(tb0 + i)] = 8'($urandom);
        wv[i] = 8'($urandom);
      end
      start_cond();
      wr_byte({a, rw}, ack); chk("rnd_addr_ack", 32'(ack), 32'(m ? ACK : NACK));
      if (m) chk("rnd_readMode", 32'(readMode), 32'(rw));
      if (m && rw)
        for (int i = 0; i < n; i++) begin
          rd_byte(i == n - 1 ? NACK : ACK, d);
          chk("rnd_rd", 32'(d), 32'(tx_arr[6'(tb0 + i)]));
        end
      else if (!rw)
        for (int i = 0; i < n; i++) begin
          wr_byte(wv[i], ack);
          chk("rnd_wr_ack", 32'(ack), 32'(m ? ACK : NACK));
        end
      stop_cond(); cyc(12);
      chk("rnd_rx_cnt", 32'(rx_cnt - rb), 32'((m && !rw) ? n : 0));
      if (m && !rw)
        for (int i = 0; i < n; i++) chk("rnd_rx", 32'(rx_log[6'(rb + i)]), 32'(wv[i]));
      chk("rnd_txloads", 32'(tx_idx - tb0), 32'((m && rw) ? n : 0));
      chk("rnd_stops", 32'(stop_cnt - sb), 1);
      chk("rnd_busy_end", 32'(busy), 0);
    end

    chk("sda_stable_scl_high", 32'(oe_bad), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
